// File: rtl/ntru_pkg.sv
// Shared NTRU constants for the lift-multiplier front end: default sizes,
// the trit and coefficient encodings, and the loader state enum.
package ntru_pkg;

  localparam int DEF_N      = 701;
  localparam int DEF_Q_BITS = 13;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_ONE  = 2'b01;
  localparam logic [1:0] TRIT_TWO  = 2'b10;

  localparam logic [12:0] Q_ZERO   = 13'd0;
  localparam logic [12:0] Q_ONE    = 13'd1;
  localparam logic [12:0] Q_MINUS1 = 13'd8191;

  typedef enum logic [1:0] {
    LOAD,
    NORM,
    HOLD
  } state_t;

  // The illegal encoding 11 reads as zero.
  function automatic logic [1:0] trit_dec(input logic [1:0] t);
    return (t == 2'b11) ? TRIT_ZERO : t;
  endfunction

endpackage

// File: rtl/s3_sub_enc.sv
// (a - b) mod 3 for two decoded trits, emitted as a signed coefficient code
// (0, +1, -1 in Q_BITS-wide two's complement).
module s3_sub_enc
  import ntru_pkg::*;
#(
  parameter int Q_BITS = DEF_Q_BITS
) (
  input  logic [1:0]        a,
  input  logic [1:0]        b,
  output logic [Q_BITS-1:0] q
);

  logic [2:0] sum;
  logic [1:0] r;

  always_comb begin
    sum = {1'b0, a} + 3'd3 - {1'b0, b};
    r   = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    case (r)
      2'd0:    q = Q_BITS'(Q_ZERO);
      2'd1:    q = Q_BITS'(Q_ONE);
      default: q = Q_BITS'(Q_MINUS1);
    endcase
  end

endmodule

// File: rtl/s3_lift_loader.sv
// Buffers one ternary frame, reduces it modulo Phi_N in NORM_PAR-wide chunks
// and presents the N-1 coefficient codes to the lift multiplier.
// Optional illegal-trit flag: define S3_LIFT_TRIT_CHECK_EN.
module s3_lift_loader
  import ntru_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int LANES    = 4,
  parameter int NORM_PAR = 100,
  parameter int Q_BITS   = DEF_Q_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*LANES-1:0]        in_trits,
  output logic                      vec_start,
  output logic [Q_BITS*(N-1)-1:0]   vec_out,
  input  logic                      lift_done,
  output logic                      busy,
  output logic                      err
);

  localparam int BEATS      = (N + LANES - 1) / LANES;
  localparam int NC         = (N - 1 + NORM_PAR - 1) / NORM_PAR;
  localparam int SW         = BEATS * LANES;
  localparam int VW         = NC * NORM_PAR;
  localparam int LAST_VALID = N - (BEATS - 1) * LANES;
  localparam int BW         = $clog2(BEATS + 1);
  localparam int CW         = $clog2(NC + 1);

  state_t                    state;
  logic [BW-1:0]             beat;
  logic [CW-1:0]             chunk;
  logic [2*SW-1:0]           store;
  logic [1:0]                top_trit;
  logic [Q_BITS*VW-1:0]      vec;
  logic [2*LANES-1:0]        dec;
  logic [Q_BITS*NORM_PAR-1:0] enc;
  logic                      accept;
  logic                      last_beat;

  assign in_ready  = (state == LOAD);
  assign busy      = (state != LOAD);
  assign accept    = in_valid && (state == LOAD);
  assign last_beat = (beat == BW'(BEATS - 1));
  assign vec_out   = vec[Q_BITS*(N-1)-1:0];

  always_comb begin
    dec = '0;
    for (int unsigned k = 0; k < LANES; k++)
      dec[2*k +: 2] = trit_dec(in_trits[2*k +: 2]);
  end

  // Beats shift in from the top so trit i lands at slot i after the last beat;
  // NORM then shifts the store down so each chunk is always read from slot 0.
  for (genvar j = 0; j < NORM_PAR; j++) begin : g_enc
    s3_sub_enc #(.Q_BITS(Q_BITS)) u_enc (
      .a (store[2*j +: 2]),
      .b (top_trit),
      .q (enc[Q_BITS*j +: Q_BITS])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      beat      <= '0;
      chunk     <= '0;
      vec_start <= 1'b0;
      vec       <= '0;
    end else begin
      vec_start <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            store <= {dec, store[2*SW-1:2*LANES]};
            if (last_beat) begin
              top_trit <= dec[2*(LAST_VALID-1) +: 2];
              beat     <= '0;
              chunk    <= '0;
              state    <= NORM;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        NORM: begin
          vec   <= {enc, vec[Q_BITS*VW-1:Q_BITS*NORM_PAR]};
          store <= store >> (2 * NORM_PAR);
          if (chunk == CW'(NC - 1)) begin
            chunk     <= '0;
            state     <= HOLD;
            vec_start <= 1'b1;
          end else begin
            chunk <= chunk + 1'b1;
          end
        end
        HOLD: begin
          if (lift_done) begin
            state <= LOAD;
            beat  <= '0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef S3_LIFT_TRIT_CHECK_EN
  logic bad;

  // Lanes past the end of the frame on the final beat are padding.
  always_comb begin
    bad = 1'b0;
    for (int unsigned k = 0; k < LANES; k++)
      if (in_trits[2*k +: 2] == 2'b11 && (!last_beat || k < LAST_VALID))
        bad = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (state == HOLD && lift_done)
      err <= 1'b0;
    else if (accept && bad)
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_s3_lift_loader.sv
// Scoreboard bench for s3_lift_loader: frames are driven with random
// backpressure, expected results are queued and checked on vec_start.
module tb_s3_lift_loader;

  localparam int N        = 701;
  localparam int LANES    = 4;
  localparam int NORM_PAR = 100;
  localparam int QB       = 13;
  localparam int BEATS    = 176;
  localparam int NC       = 7;
  localparam int VW       = QB * (N - 1);

`ifdef S3_LIFT_TRIT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [2*LANES-1:0] in_trits;
  logic               vec_start;
  logic [VW-1:0]      vec_out;
  logic               lift_done;
  logic               busy;
  logic               err;

  s3_lift_loader #(
    .N        (N),
    .LANES    (LANES),
    .NORM_PAR (NORM_PAR),
    .Q_BITS   (QB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_trits  (in_trits),
    .vec_start (vec_start),
    .vec_out   (vec_out),
    .lift_done (lift_done),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [VW-1:0] v;
    logic          e;
    int            c;
  } exp_t;

  exp_t sb[$];
  int   c[N];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // Reference: coefficient i is (c_i - c_{N-1}) mod 3, with 3 meaning "illegal, read as 0".
  function automatic logic [VW-1:0] model_vec();
    logic [VW-1:0] m;
    int ct, ci, r;
    m  = '0;
    ct = (c[N-1] == 3) ? 0 : c[N-1];
    for (int i = 0; i < N - 1; i++) begin
      ci = (c[i] == 3) ? 0 : c[i];
      r  = (ci - ct + 3) % 3;
      m[i*QB +: QB] = (r == 0) ? 13'd0 : (r == 1) ? 13'd1 : 13'd8191;
    end
    return m;
  endfunction

  function automatic bit model_err();
    bit e;
    e = 1'b0;
    for (int i = 0; i < N; i++)
      if (c[i] == 3) e = 1'b1;
    return e && CHK;
  endfunction

  task automatic send_frame(input int nbeats, input bit rnd_valid, output int last_c);
    logic [2*LANES-1:0] d;
    bit v, rdy;
    int idx, t;
    last_c = 0;
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < LANES; k++) begin
        idx = b * LANES + k;
        t   = (idx < N) ? c[idx] : int'($urandom_range(0, 3));
        d[2*k +: 2] = 2'(t);
      end
      do begin
        @(negedge clk);
        rdy      = in_ready;
        v        = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        in_valid = v;
        in_trits = v ? d : 8'($urandom);
      end while (!(v && rdy));
      last_c = cyc;
    end
  endtask

  task automatic run_frame(input bit rnd_valid, input int hold_d);
    exp_t e;
    int   lc;
    int   w;
    e.v = model_vec();
    e.e = model_err();
    send_frame(BEATS, rnd_valid, lc);
    e.c = lc + NC + 1;
    sb.push_back(e);
    w = 0;
    forever begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_trits = 8'($urandom);
      if (vec_start) break;
      check("busy_norm", {in_ready, busy}, 2'b01);
      w++;
      if (w > 40) begin
        checks++;
        errors++;
        $display("FAIL vec_start_timeout actual none required within %0d cycles", NC + 1);
        in_valid = 1'b0;
        return;
      end
    end
    repeat (hold_d) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_trits = 8'($urandom);
      check("busy_hold", {in_ready, busy, vec_start}, 3'b010);
    end
    lift_done = 1'b1;
    checks++;
    if (vec_out !== e.v) begin
      errors++;
      $display("FAIL hold_stable actual changed required held");
    end
    @(negedge clk);
    lift_done = 1'b0;
    in_valid  = 1'b0;
    check("ready_after_done", {in_ready, busy, err}, 3'b100);
  endtask

  // Monitor: pops the scoreboard on every vec_start pulse.
  initial begin
    exp_t e;
    int   bad_i;
    forever begin
      @(negedge clk);
      if (vec_start) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_vec_start actual pulse required none");
        end else begin
          e = sb.pop_front();
          checks++;
          if (vec_out !== e.v) begin
            errors++;
            bad_i = -1;
            for (int i = N - 2; i >= 0; i--)
              if (vec_out[i*QB +: QB] !== e.v[i*QB +: QB]) bad_i = i;
            $display("FAIL vec_coef%0d actual %0d required %0d", bad_i,
                     vec_out[bad_i*QB +: QB], e.v[bad_i*QB +: QB]);
          end
          check("err_flag", err, e.e);
          check("start_latency", cyc, e.c);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_trits  = '0;
    lift_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {in_ready, vec_start, busy, err}, 4'b1000);
    check("rst_vec_nonzero", (vec_out != '0), 0);
    rst = 1'b0;

    foreach (c[i]) c[i] = 0;
    run_frame(1'b0, 3);

    foreach (c[i]) c[i] = 0;
    c[0] = 1;
    run_frame(1'b1, int'($urandom_range(0, 5)));

    foreach (c[i]) c[i] = 0;
    c[N-1] = 2;
    run_frame(1'b1, 0);

    foreach (c[i]) c[i] = 1;
    run_frame(1'b1, 2);

    foreach (c[i]) c[i] = 0;
    c[3]   = 2;
    c[N-1] = 1;
    run_frame(1'b1, 20);

    foreach (c[i]) c[i] = int'($urandom_range(0, 2));
    run_frame(1'b1, 1);

    foreach (c[i]) c[i] = int'($urandom_range(0, 2));
    c[5]   = 3;
    c[N-1] = 0;
    run_frame(1'b1, 1);

    foreach (c[i]) c[i] = int'($urandom_range(0, 3));
    c[10] = 3;
    send_frame(50, 1'b1, lc);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("rst_abort", {in_ready, busy, vec_start, err}, 4'b1000);
    rst = 1'b0;

    foreach (c[i]) c[i] = int'($urandom_range(0, 2));
    run_frame(1'b1, 4);

    for (int f = 0; f < 2; f++) begin
      foreach (c[i]) c[i] = ($urandom_range(0, 99) == 0) ? 3 : int'($urandom_range(0, 2));
      run_frame(1'b1, int'($urandom_range(0, 6)));
    end

    repeat (5) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
